// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream master.
// Consumed by fifo_stream_reader and stream_skid_buf.
package fifo_stream_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // Bytes the skid buffer will still hold or owe once this cycle's pop retires.
  function automatic logic [2:0] pending_after_pop(input occ_t occ,
                                                   input logic in_flight,
                                                   input logic pop);
    return {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready byte stream, bundled for fifo_stream_reader.
// master = the reader; slave = the FIFO and the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_W = 8
) ();

  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_wr;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    input  fifo_empty, fifo_full, fifo_wr, fifo_dout, m_ready,
    output fifo_rd, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_full, fifo_wr, fifo_dout, m_ready,
    input  fifo_rd, m_valid, m_data
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry circular valid/ready skid buffer that absorbs the FIFO's one-cycle
// read latency; exposes occupancy so the reader can throttle its reads.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output occ_t              occ_o
);

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] mem_d [SKID_DEPTH];
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  occ_t              occ_q, occ_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (push_i) begin
      mem_d[tail_q] = push_data_i;
      tail_d        = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
    if (pop_i) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign valid_o     = (occ_q != 2'd0);
  assign head_data_o = mem_q[head_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the 16x8 byte FIFO, presenting bytes as a valid/ready stream.
// Optional delivered-byte counter rd_count enabled by FIFO_RD_STATS_EN.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef FIFO_RD_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                rst,
  fifo_stream_reader_if.master bus
`ifdef FIFO_RD_STATS_EN
  , output logic [STAT_W-1:0] rd_count
`endif
);

  logic              in_flight_q, in_flight_d;
  logic              pop_s;
  logic              issue_s;
  logic              accept_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  occ_t              occ_s;

  stream_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (in_flight_q),
    .push_data_i (bus.fifo_dout),
    .pop_i       (pop_s),
    .valid_o     (skid_valid_s),
    .head_data_o (skid_data_s),
    .occ_o       (occ_s)
  );

  // Read issue and acceptance; the FIFO ignores a read in any cycle it takes a write.
  always_comb begin
    pop_s       = skid_valid_s & bus.m_ready;
    issue_s     = !bus.fifo_empty && (pending_after_pop(occ_s, in_flight_q, pop_s) <= 3'd1);
    accept_s    = issue_s && !(bus.fifo_wr && !bus.fifo_full);
    in_flight_d = accept_s;
  end

  // In-flight flag: fifo_dout carries a valid byte in the following cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
    end
  end

  // Gating with rst makes the strobe drop the instant reset asserts.
  assign bus.fifo_rd = rst & issue_s;
  assign bus.m_valid = skid_valid_s;
  assign bus.m_data  = skid_data_s;

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] rd_count_q;

  // Delivered-byte counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q <= '0;
    end else if (pop_s) begin
      rd_count_q <= rd_count_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      rd_count_q <= rd_count_q;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, write-order scoreboard, directed
// and random phases. Define FIFO_RD_STATS_EN to also check rd_count (STAT_W=8).
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_clr = 1'b0;
  logic [7:0] fifo_din = 8'h00;

  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DATA_W(8)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [7:0] rd_count;
`endif

  fifo_stream_reader #(
    .DATA_W(8)
`ifdef FIFO_RD_STATS_EN
    , .STAT_W(8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RD_STATS_EN
    , .rd_count (rd_count)
`endif
  );

  // Behavioural 16x8 FIFO: registered dout, write beats read.
  logic [7:0] fq [$];
  logic       f_empty = 1'b1;
  logic       f_full  = 1'b0;
  logic [7:0] f_dout  = 8'h00;

  always @(posedge clk) begin
    if (fifo_clr) fq.delete();
    else if (bus.fifo_wr && fq.size() < 16) fq.push_back(fifo_din);
    else if (bus.fifo_rd && fq.size() > 0) f_dout <= fq.pop_front();
    f_empty <= (fq.size() == 0);
    f_full  <= (fq.size() == 16);
  end

  assign bus.fifo_empty = f_empty;
  assign bus.fifo_full  = f_full;
  assign bus.fifo_dout  = f_dout;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes leave in write order; accepted reads minus pops = bytes owed.
  logic [7:0] exp_q [$];
  int         outstanding = 0;
  int         acc_cnt = 0;
  int         del_cnt = 0;
  logic       mon_pop, mon_acc;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      outstanding = 0;
      del_cnt = 0;
    end else begin
      mon_pop = bus.m_valid && bus.m_ready;
      mon_acc = bus.fifo_rd && !bus.fifo_empty && !(bus.fifo_wr && !bus.fifo_full);
      if (bus.fifo_rd) begin
        check("rd_when_empty", bus.fifo_empty, 0);
        check("rd_without_room", (outstanding - int'(mon_pop)) <= 1, 1);
      end
      check("owed_le_2", outstanding <= 2, 1);
      if (mon_pop) begin
        if (exp_q.size() == 0) check("spurious_byte", exp_q.size(), 1);
        else begin
          check("data_order", bus.m_data, exp_q.pop_front());
          del_cnt++;
        end
      end
      if (bus.fifo_wr && !bus.fifo_full && !fifo_clr) exp_q.push_back(fifo_din);
      outstanding = outstanding + int'(mon_acc) - int'(mon_pop);
      acc_cnt = acc_cnt + int'(mon_acc);
    end
  end

  task automatic wr1(input logic [7:0] b);
    bus.fifo_wr = 1'b1;
    fifo_din = b;
    @(posedge clk); #1;
    bus.fifo_wr = 1'b0;
  endtask

  // mode 0: always ready, 1: toggling 1010..., 2: random
  task automatic drain(input int mode, input int max_cyc);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && k < max_cyc) begin
      bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    check("drain_done", (exp_q.size() == 0 && outstanding == 0), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end expected end of run");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] b5 [5];
  int         base;

  initial begin
    bus.fifo_wr = 1'b0;
    bus.m_ready = 1'b0;
    fifo_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_rd", bus.fifo_rd, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
`ifdef FIFO_RD_STATS_EN
    check("rst_rd_count", rd_count, 0);
`endif
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    rst = 1'b1;

    // Three bytes, consumer always ready: latency 2, then back-to-back.
    bus.m_ready = 1'b1;
    wr1(8'h11); wr1(8'h22); wr1(8'h33);
    @(negedge clk); check("t1_first_rd", bus.fifo_rd, 1); check("t1_v0", bus.m_valid, 0);
    @(negedge clk); check("t1_v1", bus.m_valid, 0);
    @(negedge clk); check("t1_v2", bus.m_valid, 1); check("t1_d0", bus.m_data, 8'h11);
    @(negedge clk); check("t1_d1", bus.m_data, 8'h22); check("t1_rd_empty", bus.fifo_rd, 0);
    @(negedge clk); check("t1_d2", bus.m_data, 8'h33); check("t1_v_last", bus.m_valid, 1);
    @(negedge clk); check("t1_v_end", bus.m_valid, 0);
    @(posedge clk); #1;
    drain(0, 20);

    // Backpressure: only two reads accepted, head byte held.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b5[i] = 8'($urandom);
      wr1(b5[i]);
    end
    base = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check("bp_valid", bus.m_valid, 1);
        check("bp_hold", bus.m_data, b5[0]);
      end
    end
    @(posedge clk); #1;
    check("bp_reads", acc_cnt - base, 2);
    drain(0, 40);
    check("bp_delivered", del_cnt, 8);

    // Write held while reading: reads retried, nothing captured.
    bus.m_ready = 1'b1;
    base = acc_cnt;
    bus.fifo_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fifo_din = 8'($urandom);
      @(negedge clk);
      if (i > 0) check("wr_rd_retry", bus.fifo_rd, 1);
      @(posedge clk); #1;
    end
    bus.fifo_wr = 1'b0;
    check("wr_block_reads", acc_cnt - base, 0);
    drain(0, 40);

    // 16 bytes with toggling ready.
    bus.m_ready = 1'b0;
    base = del_cnt;
    for (int i = 0; i < 16; i++) wr1(8'(i));
    check("fill_full", bus.fifo_full, 1);
    drain(1, 200);
    check("toggle_count", del_cnt - base, 16);

    // Async reset with one byte buffered and one in flight.
    bus.m_ready = 1'b0;
    wr1(8'hA1); wr1(8'hA2); wr1(8'hA3);
    for (int k = 0; k < 10 && outstanding != 2; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_owed", outstanding, 2);
    bus.m_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", bus.m_valid, 1);
    check("pre_rst_rd", bus.fifo_rd, 1);
    #2 rst = 1'b0;
    #1;
    check("async_valid", bus.m_valid, 0);
    check("async_rd", bus.fifo_rd, 0);
    @(posedge clk); #1; fifo_clr = 1'b1;
    @(posedge clk); #1; fifo_clr = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    for (int i = 0; i < 4; i++) wr1(8'hC0 + 8'(i));
    drain(0, 40);
    check("post_rst_delivered", del_cnt, 4);

`ifdef FIFO_RD_STATS_EN
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("stat_cleared", rd_count, 0);
    for (int n = 0; n < 300; n += 15) begin
      for (int i = 0; i < 15; i++) wr1(8'($urandom));
      drain(2, 200);
    end
    check("stat_300", rd_count, 8'd44);
`endif

    // Random traffic against the scoreboard.
    base = del_cnt;
    for (int i = 0; i < 400; i++) begin
      bus.fifo_wr = ($urandom_range(0, 2) == 0);
      fifo_din = 8'($urandom);
      bus.m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus.fifo_wr = 1'b0;
    drain(2, 400);
    check("rand_progress", del_cnt > base, 1);
`ifdef FIFO_RD_STATS_EN
    check("stat_wrap", rd_count, 8'(del_cnt));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
